// File: rtl/glb_wght_rd_arbiter.sv
// glb_wght_rd_arbiter: round-robin burst arbiter sharing the weight-GLB read port among router clients
module glb_wght_rd_arbiter #(
   parameter int NUM_CLIENTS       = 4,
   parameter int DATA_BITWIDTH     = 16,
   parameter int ADDR_BITWIDTH_GLB = 10,
   parameter int BURST_LEN         = 9
) (
   input  logic                                      clk,
   input  logic                                      reset,
   input  logic [NUM_CLIENTS-1:0]                    cl_req,
   input  logic [NUM_CLIENTS*ADDR_BITWIDTH_GLB-1:0]  cl_addr,
   output logic [NUM_CLIENTS-1:0]                    cl_gnt,
   output logic [DATA_BITWIDTH-1:0]                  cl_rdata,
   output logic [NUM_CLIENTS-1:0]                    cl_rvalid,
   output logic [ADDR_BITWIDTH_GLB-1:0]              r_addr_glb_wght,
   output logic                                      read_req_glb_wght,
   input  logic [DATA_BITWIDTH-1:0]                  r_data_glb_wght,
   output logic                                      busy
);
   localparam int IW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
   typedef enum logic {IDLE, GRANT} state_t;
   state_t                 state_q, state_d;
   logic [IW-1:0]          sel_q, sel_d, rr_ptr_q, rr_ptr_d, pick, idx, next_sel;
   logic [7:0]             beat_cnt_q, beat_cnt_d;
   logic [NUM_CLIENTS-1:0] gnt_q, gnt_d, rvalid_q, rvalid_d;
   logic                   found, last_beat;
   assign read_req_glb_wght = (state_q == GRANT) && cl_req[sel_q];
   assign r_addr_glb_wght   = read_req_glb_wght ? cl_addr[sel_q*ADDR_BITWIDTH_GLB +: ADDR_BITWIDTH_GLB] : '0;
   assign last_beat         = beat_cnt_q == 8'(BURST_LEN - 1);
   assign next_sel          = IW'((int'(sel_q) + 1) % NUM_CLIENTS);
   assign cl_gnt            = gnt_q;
   assign cl_rvalid         = rvalid_q;
   assign cl_rdata          = r_data_glb_wght;
   assign busy              = state_q == GRANT;
   // scan downward so the requester closest to rr_ptr is the last (winning) assignment
   always_comb begin
      pick  = rr_ptr_q;
      idx   = rr_ptr_q;
      found = 1'b0;
      for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
         idx = IW'((int'(rr_ptr_q) + k) % NUM_CLIENTS);
         if (cl_req[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
   end
   // arbitration, burst counting and release back to IDLE
   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      rr_ptr_d   = rr_ptr_q;
      beat_cnt_d = beat_cnt_q;
      gnt_d      = gnt_q;
      rvalid_d   = read_req_glb_wght ? NUM_CLIENTS'(1) << sel_q : '0;
      if (state_q == IDLE) begin
         if (found) begin
            state_d    = GRANT;
            sel_d      = pick;
            gnt_d      = NUM_CLIENTS'(1) << pick;
            beat_cnt_d = '0;
         end
      end else if (read_req_glb_wght && !last_beat) begin
         beat_cnt_d = beat_cnt_q + 8'd1;
      end else begin
         state_d  = IDLE;
         gnt_d    = '0;
         rr_ptr_d = next_sel;
      end
   end
   // state registers with asynchronous clear
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         sel_q      <= '0;
         rr_ptr_q   <= '0;
         beat_cnt_q <= '0;
         gnt_q      <= '0;
         rvalid_q   <= '0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         rr_ptr_q   <= rr_ptr_d;
         beat_cnt_q <= beat_cnt_d;
         gnt_q      <= gnt_d;
         rvalid_q   <= rvalid_d;
      end
   end
endmodule

// File: doc/glb_wght_rd_arbiter.md
Name: glb_wght_rd_arbiter

Overview:
Round-robin arbiter that shares the single weight-GLB read port among NUM_CLIENTS weight routers. Each router requests the port, receives a registered one-hot grant and issues up to BURST_LEN consecutive reads. Returned data is broadcast to all routers, with a per-client valid one cycle after each issued read. The block sits between the weight GLB and the per-PE-row weight routers.

Parameters:
NUM_CLIENTS, 4, number of router clients (≥2)
DATA_BITWIDTH, 16, GLB data width
ADDR_BITWIDTH_GLB, 10, GLB address width
BURST_LEN, 9, maximum reads per grant (kernel_size**2); legal range 1..255

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
cl_req  in  NUM_CLIENTS  per-client read request; held high while client wants beats
cl_addr  in  NUM_CLIENTS*ADDR_BITWIDTH_GLB  packed per-client read address; client i at [i*A +: A]
cl_gnt  out  NUM_CLIENTS  registered one-hot grant
cl_rdata  out  DATA_BITWIDTH  broadcast read data (= r_data_glb_wght)
cl_rvalid  out  NUM_CLIENTS  one-hot: cl_rdata is valid for client i this cycle
r_addr_glb_wght  out  ADDR_BITWIDTH_GLB  GLB read address
read_req_glb_wght  out  1  GLB read enable
r_data_glb_wght  in  DATA_BITWIDTH  GLB read data, valid 1 cycle after read_req_glb_wght
busy  out  1  high while a grant is held

Behaviour:
- Reset (async, active-high): state=IDLE, cl_gnt=0, cl_rvalid=0, rr_ptr=0, beat_cnt=0, busy=0. read_req_glb_wght=0 and r_addr_glb_wght=0 because no grant is held.
- States: IDLE, GRANT.
- IDLE:
  - If any cl_req is high, select the first requester scanning rr_ptr, rr_ptr+1, … (mod NUM_CLIENTS).
  - Next edge: cl_gnt<=onehot(sel), sel registered, beat_cnt<=0, state<=GRANT.
  - If no requests, stay in IDLE.
  - The first read of a burst is therefore issued no earlier than 1 cycle after the request appears.
- GRANT:
  - read_req_glb_wght = cl_req[sel] (combinational).
  - r_addr_glb_wght = cl_addr[sel] when read_req_glb_wght is high, else 0.
  - busy=1.
  - On each edge with cl_req[sel]=1: one beat is issued, beat_cnt++.
  - If the issued beat is number BURST_LEN (beat_cnt==BURST_LEN-1): cl_gnt<=0, rr_ptr<=(sel+1) mod N, state<=IDLE.
  - If cl_req[sel]=0 in GRANT: no read is issued that cycle; grant is released at the edge (cl_gnt<=0, rr_ptr<=sel+1, state<=IDLE).
- Read return:
  - cl_rvalid is registered: cl_rvalid<=onehot(sel) if a beat was issued this cycle, else 0.
  - cl_rdata is a combinational pass-through of r_data_glb_wght.
  - The rvalid pipeline runs independently of state, so the last beat's rvalid appears in the IDLE cycle after release.
- Throughput:
  - Back-to-back beats within a grant: 1 per cycle.
  - One IDLE arbitration bubble between grants. A sole persistent requester therefore gets BURST_LEN reads, then 1 idle cycle, repeating.
- Fairness: rr_ptr only advances on release, to sel+1. It is not changed in IDLE without a grant.
- Requests changing in IDLE are sampled only at the arbitration edge. Non-granted requests are ignored during GRANT.
- Reset mid-burst: cl_gnt and cl_rvalid clear immediately; in-flight data is discarded.
- cl_rvalid is always one-hot or zero. At most one cl_gnt bit is ever high.

Test Plan:
- Single client: cl_req[0] high continuously, cl_addr[0] incrementing from 0, BURST_LEN=9 -> cl_gnt[0] 1 cycle after req; 9 read_req pulses with addr 0..8; cl_rvalid[0] pulses lagging by 1; then 1 idle cycle; re-grant to client 0.
- All 4 clients request at once from reset -> grants in order 0,1,2,3,0, each 9 beats. No two cl_gnt bits are ever high together. cl_rvalid tags match the issuing client.
- Client 2 drops cl_req after 4 beats -> exactly 4 reads issued and 4 cl_rvalid[2] pulses. Release; rr_ptr=3; the next grant goes to client 3 if it is requesting.
- BURST_LEN=1 with clients 1 and 3 requesting -> alternating single-beat grants 1,3,1,3 with one idle cycle between them.
- Reset asserted asynchronously mid-burst (beat 5) -> cl_gnt, cl_rvalid, read_req_glb_wght go 0 without a clock edge. After release, arbitration restarts from client 0.
- Data check: GLB model returns addr+0x100 one cycle after read -> cl_rdata equals addr+0x100 on every cl_rvalid cycle for every client.
